// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline-control FSM states and the
// bundled stage-enable/flush control word.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_t;

  // Fields in declaration order: pc, ifid, idex, exmem, memwb enables, then
  // ifid, idex, exmem, memwb flushes.
  localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_DSTALL   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_HALT_ENT = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FMISS    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FROZEN   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for hazard statistics.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/halt controller: stage enables and bubble flushes.
// Optional HAZARD_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ihit,
  input  logic         dhit,
  input  regbits_t     id_rs,
  input  regbits_t     id_rt,
  input  logic         ex_dREN,
  input  regbits_t     ex_wsel,
  input  logic         ex_redirect,
  input  logic         mem_dREN,
  input  logic         mem_dWEN,
  input  logic         mem_halt,
  output logic         pc_en,
  output logic         ifid_en,
  output logic         idex_en,
  output logic         exmem_en,
  output logic         memwb_en,
  output logic         ifid_flush,
  output logic         idex_flush,
  output logic         exmem_flush,
  output logic         memwb_flush,
  output logic         halt,
`ifdef HAZARD_STATS_EN
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt,
`endif
  output pctrl_state_t state_dbg
);

  pctrl_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         halt_q, halt_d;
  ctrl_t        ctrl;
  logic         data_stall, load_use, redirect_win;

  assign data_stall = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use   = ex_dREN && (ex_wsel != '0) &&
                      ((ex_wsel == id_rs) || (ex_wsel == id_rt));

  always_comb begin
    ctrl         = CTRL_NORMAL;
    state_d      = state_q;
    cnt_d        = cnt_q;
    halt_d       = halt_q;
    redirect_win = 1'b0;
    if (RST) begin
      ctrl = CTRL_FROZEN;
    end else begin
      unique case (state_q)
        RUN, DWAIT: begin
          // DWAIT only releases on dhit, then decodes exactly like RUN.
          if (data_stall || ((state_q == DWAIT) && !dhit)) begin
            ctrl    = CTRL_DSTALL;
            state_d = DWAIT;
          end else begin
            state_d = RUN;
            if (mem_halt) begin
              ctrl    = CTRL_HALT_ENT;
              cnt_d   = 4'(DRAIN_CYCLES - 1);
              state_d = DRAIN;
            end else if (ex_redirect) begin
              ctrl         = CTRL_REDIRECT;
              redirect_win = 1'b1;
            end else if (load_use) begin
              ctrl = CTRL_LOADUSE;
            end else if (!ihit) begin
              ctrl = CTRL_FMISS;
            end
          end
        end
        DRAIN: begin
          ctrl = CTRL_HALT_ENT;
          if (cnt_q == '0) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        HALTED: begin
          ctrl   = CTRL_FROZEN;
          halt_d = 1'b1;
        end
        default: ctrl = CTRL_FROZEN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign halt        = halt_q;
  assign state_dbg   = state_q;

`ifdef HAZARD_STATS_EN
  sat_counter #(.W(32)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (!ctrl.pc_en && (state_q != HALTED)),
    .count (stall_cnt)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (redirect_win),
    .count (flush_cnt)
  );
`else
  logic unused_redirect;
  assign unused_redirect = redirect_win;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard priorities, data-wait, halt/drain,
// reset recovery and (with HAZARD_STATS_EN) the statistics counters.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic         CLK = 1'b0;
  logic         RST;
  logic         ihit, dhit;
  regbits_t     id_rs, id_rt, ex_wsel;
  logic         ex_dREN, ex_redirect, mem_dREN, mem_dWEN, mem_halt;
  logic         pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic         ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic         halt;
  pctrl_state_t state_dbg;
`ifdef HAZARD_STATS_EN
  logic [31:0]  stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  // Expected control words: {pc,ifid,idex,exmem,memwb en ; ifid,idex,exmem,memwb flush}
  localparam logic [8:0] V_NORMAL = 9'b11111_0000;
  localparam logic [8:0] V_DSTALL = 9'b00001_0001;
  localparam logic [8:0] V_HALTEN = 9'b01111_1110;
  localparam logic [8:0] V_REDIR  = 9'b11111_1100;
  localparam logic [8:0] V_LDUSE  = 9'b00111_0100;
  localparam logic [8:0] V_FMISS  = 9'b01111_1000;
  localparam logic [8:0] V_FROZEN = 9'b00000_1111;

  pipeline_ctrl #(.DRAIN_CYCLES(2)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .dhit        (dhit),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_dREN     (ex_dREN),
    .ex_wsel     (ex_wsel),
    .ex_redirect (ex_redirect),
    .mem_dREN    (mem_dREN),
    .mem_dWEN    (mem_dWEN),
    .mem_halt    (mem_halt),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .memwb_flush (memwb_flush),
    .halt        (halt),
`ifdef HAZARD_STATS_EN
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // Clock: 10 time-unit period.
  always #5 CLK = ~CLK;

  function automatic logic [8:0] ctrl_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
            ifid_flush, idex_flush, exmem_flush, memwb_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0;
    id_rs = '0; id_rt = '0; ex_wsel = '0;
    ex_dREN = 1'b0; ex_redirect = 1'b0;
    mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
  endtask

  // Inputs are applied 1 unit after posedge; combinational outputs are
  // sampled on the following negedge, then we advance past the next posedge.
  task automatic cycle_check(input string tag, input logic [8:0] exp_v,
                             input pctrl_state_t exp_st);
    exp_q.push_back(exp_v);
    @(negedge CLK);
    check({tag, ".ctrl"}, 32'(ctrl_vec()), 32'(exp_q.pop_front()));
    check({tag, ".state"}, 32'(state_dbg), 32'(exp_st));
    @(posedge CLK); #1;
  endtask

  initial begin
    idle();
    RST = 1'b1;
    @(posedge CLK); #1;
    cycle_check("reset", V_FROZEN, RUN);
    check("reset.halt", 32'(halt), 32'd0);
    RST = 1'b0;

    cycle_check("normal", V_NORMAL, RUN);

    ex_dREN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
    cycle_check("loaduse_rs", V_LDUSE, RUN);
    idle();
    cycle_check("loaduse_clear", V_NORMAL, RUN);

    ex_dREN = 1'b1; ex_wsel = 5'd7; id_rt = 5'd7; id_rs = 5'd3;
    cycle_check("loaduse_rt", V_LDUSE, RUN);
    idle();

    ex_dREN = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
    cycle_check("loaduse_r0", V_NORMAL, RUN);
    idle();

    ihit = 1'b0;
    cycle_check("fetch_miss", V_FMISS, RUN);
    ex_dREN = 1'b1; ex_wsel = 5'd9; id_rs = 5'd9;
    cycle_check("loaduse_over_fmiss", V_LDUSE, RUN);
    ex_redirect = 1'b1;
    cycle_check("redirect_over_loaduse", V_REDIR, RUN);
    idle();
    ex_redirect = 1'b1;
    cycle_check("redirect", V_REDIR, RUN);
    idle();

    // Load waits three cycles for dhit, released on the fourth.
    mem_dREN = 1'b1;
    cycle_check("dwait1", V_DSTALL, RUN);
    cycle_check("dwait2", V_DSTALL, DWAIT);
    cycle_check("dwait3", V_DSTALL, DWAIT);
    dhit = 1'b1;
    cycle_check("dwait_release", V_NORMAL, DWAIT);
    idle();
    cycle_check("dwait_back_run", V_NORMAL, RUN);

    // Store stall beats redirect; redirect only takes effect once dhit arrives.
    mem_dWEN = 1'b1; ex_redirect = 1'b1;
    cycle_check("dstall_over_redir1", V_DSTALL, RUN);
    cycle_check("dstall_over_redir2", V_DSTALL, DWAIT);
    dhit = 1'b1;
    cycle_check("redir_after_dhit", V_REDIR, DWAIT);
    idle();

    // Data stall beats halt, then halt entry from DWAIT on dhit.
    mem_halt = 1'b1; mem_dREN = 1'b1; ex_redirect = 1'b1;
    cycle_check("dstall_over_halt", V_DSTALL, RUN);
    dhit = 1'b1;
    cycle_check("halt_entry", V_HALTEN, DWAIT);
    idle();
    ihit = 1'b0; ex_redirect = 1'b1;
    cycle_check("drain1", V_HALTEN, DRAIN);
    check("drain1.halt", 32'(halt), 32'd0);
    cycle_check("drain2", V_HALTEN, DRAIN);
    check("halted.halt", 32'(halt), 32'd1);
    mem_dREN = 1'b1;
    cycle_check("halted1", V_FROZEN, HALTED);
    idle();
    cycle_check("halted2", V_FROZEN, HALTED);
    check("halted.sticky", 32'(halt), 32'd1);

    RST = 1'b1;
    cycle_check("rst_from_halted", V_FROZEN, HALTED);
    check("rst.halt", 32'(halt), 32'd0);
    RST = 1'b0;
    cycle_check("run_after_rst", V_NORMAL, RUN);

`ifdef HAZARD_STATS_EN
    check("stats.clear_stall", stall_cnt, 32'd0);
    check("stats.clear_flush", flush_cnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ex_redirect = 1'b1;
      cycle_check("stats_redir", V_REDIR, RUN);
      idle();
    end
    for (int i = 0; i < 3; i++) begin
      ihit = 1'b0;
      cycle_check("stats_fmiss", V_FMISS, RUN);
      idle();
    end
    check("stats.stall_cnt", stall_cnt, 32'd3);
    check("stats.flush_cnt", flush_cnt, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
